// File: rtl/alu_stage.sv
// Execute-stage ALU: logic, add/sub, compare and shift ops on two operands,
// with result, zero and signed-overflow flags registered one clock later.
module alu_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Func,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_XOR  = 4'b0010;
  localparam logic [3:0] F_XNOR = 4'b0011;
  localparam logic [3:0] F_ADD  = 4'b0100;
  localparam logic [3:0] F_SUB  = 4'b1100;
  localparam logic [3:0] F_SLT  = 4'b0101;
  localparam logic [3:0] F_SLTU = 4'b1101;
  localparam logic [3:0] F_SLL  = 4'b1000;
  localparam logic [3:0] F_SRL  = 4'b1001;
  localparam logic [3:0] F_SRA  = 4'b1011;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             out_valid_q;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [SHW-1:0]   shamt_c;
  logic             sign_a_c;
  logic             sign_b_c;

  assign sum_c    = In1 + In2;
  assign diff_c   = In1 - In2;
  assign shamt_c  = In2[SHW-1:0];
  assign sign_a_c = In1[WIDTH-1];
  assign sign_b_c = In2[WIDTH-1];

  // Operation decode; unlisted codes yield zero with no overflow.
  always_comb begin
    alu_out_d  = '0;
    overflow_d = 1'b0;
    unique case (Func)
      F_AND:  alu_out_d = In1 & In2;
      F_OR:   alu_out_d = In1 | In2;
      F_XOR:  alu_out_d = In1 ^ In2;
      F_XNOR: alu_out_d = ~(In1 ^ In2);
      F_ADD: begin
        alu_out_d  = sum_c;
        overflow_d = (sign_a_c == sign_b_c) && (sum_c[WIDTH-1] != sign_a_c);
      end
      F_SUB: begin
        alu_out_d  = diff_c;
        overflow_d = (sign_a_c != sign_b_c) && (diff_c[WIDTH-1] != sign_a_c);
      end
      F_SLT:  alu_out_d = WIDTH'($signed(In1) < $signed(In2));
      F_SLTU: alu_out_d = WIDTH'(In1 < In2);
      F_SLL:  alu_out_d = In1 << shamt_c;
      F_SRL:  alu_out_d = In1 >> shamt_c;
      F_SRA:  alu_out_d = WIDTH'($signed(In1) >>> shamt_c);
      default: begin
        alu_out_d  = '0;
        overflow_d = 1'b0;
      end
    endcase
    zero_d = (alu_out_d == '0);
  end

  // Result and flags load only on a valid input; they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        alu_out_q  <= alu_out_d;
        zero_q     <= zero_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign alu_out   = alu_out_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: directed vectors push expected results,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_alu_stage;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] In1;
  logic [W-1:0] In2;
  logic [3:0]   Func;
  logic [W-1:0] alu_out;
  logic         out_valid;
  logic         zero;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_stage #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .In1      (In1),
    .In2      (In2),
    .Func     (Func),
    .alu_out  (alu_out),
    .out_valid(out_valid),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic z, input logic ov);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    Func     = f;
    In1      = a;
    In2      = b;
    e.res = r;
    e.z   = z;
    e.ov  = ov;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    Func     = 4'bxxxx;
  endtask

  // Monitor: every presented result must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", alu_out, e.res);
          chk("sb_zero", 32'(zero), 32'(e.z));
          chk("sb_overflow", 32'(overflow), 32'(e.ov));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    Func     = 4'b0000;
    In1      = '0;
    In2      = '0;
    #12;
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    Func  = 4'bxxxx;

    // X on Func while idle must leave outputs untouched.
    repeat (2) @(posedge clk);
    #1;
    chk("xfunc_out_valid", 32'(out_valid), 32'd0);
    chk("xfunc_alu_out", alu_out, 32'd0);
    chk("xfunc_zero", 32'(zero), 32'd0);

    // Logic ops
    send(4'b0000, 32'd5, 32'd10, 32'd0, 1'b1, 1'b0);
    send(4'b0001, 32'd5, 32'd10, 32'd15, 1'b0, 1'b0);
    send(4'b0010, 32'd5, 32'd11, 32'd14, 1'b0, 1'b0);
    send(4'b0011, 32'd5, 32'd11, 32'hFFFF_FFF1, 1'b0, 1'b0);
    // Arithmetic
    send(4'b0100, 32'd5, 32'd11, 32'd16, 1'b0, 1'b0);
    send(4'b1100, 32'd5, 32'd11, 32'hFFFF_FFFA, 1'b0, 1'b0);
    send(4'b0100, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    send(4'b1100, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(4'b0100, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1);
    send(4'b1100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    // Compare
    send(4'b0101, 32'd5, 32'd11, 32'd1, 1'b0, 1'b0);
    send(4'b1101, 32'd5, 32'd11, 32'd1, 1'b0, 1'b0);
    send(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    send(4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    send(4'b0101, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    send(4'b1101, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    // Shifts
    send(4'b1000, 32'h8000_0001, 32'd4, 32'h0000_0010, 1'b0, 1'b0);
    send(4'b1001, 32'h8000_0001, 32'd4, 32'h0800_0000, 1'b0, 1'b0);
    send(4'b1011, 32'h8000_0001, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
    send(4'b1000, 32'h8000_0001, 32'h24, 32'h0000_0010, 1'b0, 1'b0);
    send(4'b1011, 32'h8000_0001, 32'h24, 32'hF800_0000, 1'b0, 1'b0);
    send(4'b1011, 32'h8000_0001, 32'd0, 32'h8000_0001, 1'b0, 1'b0);
    send(4'b1001, 32'h8000_0001, 32'd0, 32'h8000_0001, 1'b0, 1'b0);
    // Undefined codes give zero and never overflow
    send(4'b0111, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    send(4'b1111, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    idle();

    // Three back-to-back valids, then a hold cycle
    send(4'b0010, 32'd5, 32'd11, 32'd14, 1'b0, 1'b0);
    send(4'b1100, 32'd5, 32'd11, 32'hFFFF_FFFA, 1'b0, 1'b0);
    chk("stream_valid_1", 32'(out_valid), 32'd1);
    send(4'b0100, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    chk("stream_valid_2", 32'(out_valid), 32'd1);
    idle();
    chk("stream_valid_3", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    chk("hold_out_valid", 32'(out_valid), 32'd0);
    chk("hold_alu_out", alu_out, 32'h8000_0000);
    chk("hold_overflow", 32'(overflow), 32'd1);
    chk("hold_zero", 32'(zero), 32'd0);

    // Asynchronous reset while a result is being presented
    send(4'b0001, 32'd5, 32'd10, 32'd15, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_out", alu_out, 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b0100, 32'd5, 32'd11, 32'd16, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("post_reset_latency", 32'(out_valid), 32'd1);
    idle();

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
